// File: rtl/irom_fetch_responder_pkg.sv
// irom_fetch_responder_pkg: shared widths, the NOP encoding and the buffered response record.
package irom_fetch_responder_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
      logic            err;
   } rsp_t;
endpackage

// File: rtl/fetch_rsp_fifo.sv
// fetch_rsp_fifo: small synchronous FIFO with flush; head is read combinationally.
module fetch_rsp_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end
   assign dout  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
endmodule

// File: rtl/irom_fetch_responder.sv
// irom_fetch_responder: fetch-side responder; one-cycle ROM read, buffered {pc, inst, err} responses.
module irom_fetch_responder
   import irom_fetch_responder_pkg::*;
#(
   parameter int          ADDR_W     = 14,
   parameter int          FIFO_DEPTH = 2,
   parameter logic [31:0] NOP_INST   = INST_NOP
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [XLEN-1:0]   req_addr,
   input  logic              flush,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [XLEN-1:0]   rom_rdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [XLEN-1:0]   rsp_pc,
   output logic [XLEN-1:0]   rsp_inst,
   output logic              rsp_err
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   logic              req_fire;
   logic              inflight;
   logic              err_q;
   logic [XLEN-1:0]   pc_q;
   logic [ADDR_W-1:0] addr_q;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   logic [CW-1:0]     count;
   rsp_t              din;
   rsp_t              dout;
   // Credit uses the registered count so rsp_ready never reaches req_ready combinationally.
   assign req_ready = rst_n && !flush && ((count + CW'(inflight)) < CW'(FIFO_DEPTH));
   assign req_fire  = req_valid && req_ready;
   assign rom_addr  = req_fire ? req_addr[ADDR_W+1:2] : addr_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight <= 1'b0;
         err_q    <= 1'b0;
         pc_q     <= '0;
         addr_q   <= '0;
      end else begin
         inflight <= req_fire;
         if (req_fire) begin
            pc_q   <= req_addr;
            err_q  <= |req_addr[1:0];
            addr_q <= req_addr[ADDR_W+1:2];
         end
      end
   end
   assign push = inflight && !flush;
   assign pop  = rsp_valid && rsp_ready;
   assign din  = '{pc: pc_q, inst: err_q ? NOP_INST : rom_rdata, err: err_q};
   fetch_rsp_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (din),
      .dout  (dout),
      .full  (full),
      .empty (empty),
      .count (count)
   );
   assign rsp_valid = !empty;
   assign rsp_pc    = dout.pc;
   assign rsp_inst  = dout.inst;
   assign rsp_err   = dout.err;
   assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
endmodule

// File: tb/tb_irom_fetch_responder.sv
// tb_irom_fetch_responder: directed vector table plus reset, hold and ordering sequences.
module tb_irom_fetch_responder;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic        flush = 1'b0;
   logic [13:0] rom_addr;
   logic [31:0] rom_rdata;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_pc;
   logic [31:0] rsp_inst;
   logic        rsp_err;
   int checks = 0;
   int failures = 0;

   irom_fetch_responder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .flush     (flush),
      .rom_addr  (rom_addr),
      .rom_rdata (rom_rdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_pc    (rsp_pc),
      .rsp_inst  (rsp_inst),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) rom_rdata <= 32'hA000_0000 | {18'b0, rom_addr};

   typedef struct {
      logic        rv;
      logic [31:0] a;
      logic        rr;
      logic        fl;
      logic        e_rdy;
      logic        e_vld;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      logic        e_err;
   } vec_t;
   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic rv, input logic [31:0] a, input logic rr, input logic fl,
                      input logic er, input logic ev, input logic [31:0] pc = 0,
                      input logic [31:0] inst = 0, input logic err = 0);
      vecs.push_back('{rv, a, rr, fl, er, ev, pc, inst, err});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      logic [31:0] exp_q[$];
      logic [31:0] e, held_pc, held_inst;
      logic [31:0] va;
      logic        stalled;
      int          sent, got, budget;
      // streaming: credit rule admits two fetches per three cycles with depth 2
      add(1, 32'h0, 1, 0, 1, 0);
      add(1, 32'h4, 1, 0, 1, 0);
      add(1, 32'h8, 1, 0, 0, 1, 32'h0, 32'hA000_0000);
      add(1, 32'h8, 1, 0, 1, 1, 32'h4, 32'hA000_0001);
      add(1, 32'hC, 1, 0, 1, 0);
      add(0, 32'h0, 1, 0, 0, 1, 32'h8, 32'hA000_0002);
      add(0, 32'h0, 1, 0, 1, 1, 32'hC, 32'hA000_0003);
      add(0, 32'h0, 1, 0, 1, 0);
      // backpressure
      add(1, 32'h10, 0, 0, 1, 0);
      add(1, 32'h14, 0, 0, 1, 0);
      add(1, 32'h18, 0, 0, 0, 1, 32'h10, 32'hA000_0004);
      add(1, 32'h18, 0, 0, 0, 1, 32'h10, 32'hA000_0004);
      add(1, 32'h18, 1, 0, 0, 1, 32'h10, 32'hA000_0004);
      add(1, 32'h18, 1, 0, 1, 1, 32'h14, 32'hA000_0005);
      add(0, 32'h0, 1, 0, 1, 0);
      add(0, 32'h0, 1, 0, 1, 1, 32'h18, 32'hA000_0006);
      add(0, 32'h0, 1, 0, 1, 0);
      // flush with one buffered and one in flight
      add(1, 32'h20, 0, 0, 1, 0);
      add(1, 32'h24, 0, 0, 1, 0);
      add(1, 32'h28, 1, 1, 0, 1, 32'h20, 32'hA000_0008);
      add(1, 32'h100, 1, 0, 1, 0);
      add(0, 32'h0, 1, 0, 1, 0);
      add(0, 32'h0, 1, 0, 1, 1, 32'h100, 32'hA000_0040);
      add(0, 32'h0, 1, 0, 1, 0);
      // flush with a full buffer
      add(1, 32'h30, 0, 0, 1, 0);
      add(1, 32'h34, 0, 0, 1, 0);
      add(1, 32'h38, 0, 0, 0, 1, 32'h30, 32'hA000_000C);
      add(1, 32'h38, 0, 1, 0, 1, 32'h30, 32'hA000_000C);
      add(0, 32'h0, 1, 0, 1, 0);
      add(0, 32'h0, 1, 0, 1, 0);
      // misaligned
      add(1, 32'h22, 1, 0, 1, 0);
      add(0, 32'h0, 1, 0, 1, 0);
      add(0, 32'h0, 1, 0, 1, 1, 32'h22, 32'h0000_0013, 1);
      add(0, 32'h0, 1, 0, 1, 0);
      // high address bits alias
      add(1, 32'h8001_FFFC, 1, 0, 1, 0);
      add(0, 32'h0, 1, 0, 1, 0);
      add(0, 32'h0, 1, 0, 1, 1, 32'h8001_FFFC, 32'hA000_3FFF);
      add(0, 32'h0, 1, 0, 1, 0);

      req_valid = 1'b1;
      req_addr  = 32'h44;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_req_ready", req_ready, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_pc", rsp_pc, 0);
      chk("reset_rsp_inst", rsp_inst, 0);
      chk("reset_rsp_err", rsp_err, 0);
      chk("reset_rom_addr", rom_addr, 0);
      rst_n = 1'b1;
      req_valid = 1'b0;
      step();

      foreach (vecs[i]) begin
         req_valid = vecs[i].rv;
         req_addr  = vecs[i].a;
         rsp_ready = vecs[i].rr;
         flush     = vecs[i].fl;
         #1;
         chk($sformatf("v%0d_req_ready", i), req_ready, vecs[i].e_rdy);
         chk($sformatf("v%0d_rsp_valid", i), rsp_valid, vecs[i].e_vld);
         if (vecs[i].e_vld) begin
            chk($sformatf("v%0d_rsp_pc", i), rsp_pc, vecs[i].e_pc);
            chk($sformatf("v%0d_rsp_inst", i), rsp_inst, vecs[i].e_inst);
            chk($sformatf("v%0d_rsp_err", i), rsp_err, vecs[i].e_err);
         end
         if (vecs[i].rv && vecs[i].e_rdy) begin
            va = vecs[i].a;
            chk($sformatf("v%0d_rom_addr", i), {18'b0, rom_addr}, {18'b0, va[15:2]});
         end
         step();
      end
      req_valid = 1'b0;
      flush     = 1'b0;

      // reset in the middle of operation with two entries buffered
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_addr  = 32'h40;
      step();
      req_addr  = 32'h44;
      step();
      req_valid = 1'b0;
      step();
      step();
      chk("pre_reset_valid", rsp_valid, 1);
      chk("pre_reset_pc", rsp_pc, 32'h40);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_rsp_valid", rsp_valid, 0);
      chk("midrst_rsp_pc", rsp_pc, 0);
      chk("midrst_rsp_inst", rsp_inst, 0);
      chk("midrst_req_ready", req_ready, 0);
      step();
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("postrst_valid_%0d", k), rsp_valid, 0);
         step();
      end
      req_valid = 1'b1;
      req_addr  = 32'h48;
      step();
      req_valid = 1'b0;
      #1;
      chk("postrst_first_valid", rsp_valid, 0);
      step();
      chk("postrst_rsp_valid", rsp_valid, 1);
      chk("postrst_rsp_pc", rsp_pc, 32'h48);
      chk("postrst_rsp_inst", rsp_inst, 32'hA000_0012);
      step();

      // ordering and hold-stability under random backpressure
      sent = 0;
      got = 0;
      budget = 0;
      stalled = 1'b0;
      held_pc = '0;
      held_inst = '0;
      while (got < 10 && budget < 400) begin
         req_valid = (sent < 10);
         req_addr  = 32'h200 + 32'(sent * 4);
         rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (stalled && rsp_valid) begin
            chk("hold_pc", rsp_pc, held_pc);
            chk("hold_inst", rsp_inst, held_inst);
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) chk("sb_unexpected_rsp", rsp_pc, 32'hFFFF_FFFF);
            else begin
               e = exp_q.pop_front();
               chk("sb_pc", rsp_pc, e);
               chk("sb_inst", rsp_inst, 32'hA000_0000 | {18'b0, e[15:2]});
            end
            got++;
         end
         stalled   = rsp_valid && !rsp_ready;
         held_pc   = rsp_pc;
         held_inst = rsp_inst;
         if (req_valid && req_ready) begin
            exp_q.push_back(req_addr);
            sent++;
         end
         step();
         budget++;
      end
      chk("sb_received", 32'(got), 32'd10);
      req_valid = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
